// File: rtl/mem_access_unit.sv
// Load/store unit between a single-request port and a 4-byte-wide little-endian memory.
// Sub-word stores use read-modify-write; out-of-range or illegal-size requests are rejected.
module mem_access_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_BYTES  = 36
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_err,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic [31:0]           mem_wd,
  input  logic [31:0]           mem_rd
);

  // state  | meaning
  // IDLE   | ready for a request
  // RD     | load: memory read, result captured on exit
  // WR     | word store: write cycle
  // RMW_RD | sub-word store: capture surrounding word
  // RMW_WR | sub-word store: write merged word
  // RESP   | one-cycle response pulse
  typedef enum logic [2:0] {IDLE, RD, WR, RMW_RD, RMW_WR, RESP} state_t;

  localparam logic [ADDR_WIDTH:0] LIMIT = (ADDR_WIDTH+1)'(MEM_BYTES);
  localparam logic [ADDR_WIDTH:0] XFER  = (ADDR_WIDTH+1)'(4);

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [1:0]            size_q;
  logic                  signed_q;
  logic [31:0]           wdata_q;
  logic [31:0]           data_q;
  logic                  err_q;

  logic                  range_err_d;
  logic [31:0]           load_d;
  logic [31:0]           merge_d;
  logic                  mem_active;

  // One extra bit keeps the bound check free of wraparound near the top of the address space.
  assign range_err_d = ({1'b0, req_addr} + XFER) > LIMIT;

  always_comb begin
    load_d = mem_rd;
    case (size_q)
      2'b00:   load_d = {{24{signed_q & mem_rd[7]}},  mem_rd[7:0]};
      2'b01:   load_d = {{16{signed_q & mem_rd[15]}}, mem_rd[15:0]};
      default: load_d = mem_rd;
    endcase
  end

  assign merge_d = (size_q == 2'b00) ? {data_q[31:8],  wdata_q[7:0]}
                                     : {data_q[31:16], wdata_q[15:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      size_q   <= '0;
      signed_q <= 1'b0;
      wdata_q  <= '0;
      data_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            addr_q   <= req_addr;
            size_q   <= req_size;
            signed_q <= req_signed;
            wdata_q  <= req_wdata;
            data_q   <= '0;
            if (req_size == 2'b11 || range_err_d) begin
              err_q   <= 1'b1;
              state_q <= RESP;
            end else if (!req_we) begin
              state_q <= RD;
            end else if (req_size == 2'b10) begin
              state_q <= WR;
            end else begin
              state_q <= RMW_RD;
            end
          end
        end
        RD: begin
          data_q  <= load_d;
          state_q <= RESP;
        end
        WR:     state_q <= RESP;
        RMW_RD: begin
          data_q  <= mem_rd;
          state_q <= RMW_WR;
        end
        RMW_WR: begin
          data_q  <= '0;
          state_q <= RESP;
        end
        RESP: begin
          data_q  <= '0;
          err_q   <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_active = (state_q == RD) || (state_q == WR) ||
                      (state_q == RMW_RD) || (state_q == RMW_WR);

  assign req_ready  = rst_n && (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = resp_valid ? data_q : 32'h0;
  assign resp_err   = resp_valid & err_q;
  assign mem_we     = (state_q == WR) || (state_q == RMW_WR);
  assign mem_addr   = mem_active ? addr_q : '0;
  assign mem_wd     = (state_q == WR)     ? wdata_q :
                      (state_q == RMW_WR) ? merge_d : 32'h0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: directed requests push expected responses,
// a monitor pops and checks data, error flag and latency against a byte-array memory.
module tb_mem_access_unit;
  localparam int AW = 32;
  localparam int MB = 36;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid, req_ready, req_we, req_signed;
  logic [1:0]    req_size;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic          resp_valid, resp_err, mem_we;
  logic [31:0]   resp_rdata, mem_wd, mem_rd;
  logic [AW-1:0] mem_addr;

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_WIDTH(AW), .MEM_BYTES(MB)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  logic [7:0] mem [0:63];
  logic       preload_req;
  int         we_cnt;

  function automatic logic [5:0] mi(input logic [AW-1:0] a);
    return a[5:0];
  endfunction

  function automatic logic [7:0] pre_byte(input int i);
    case (i)
      0: return 8'h11;
      1: return 8'h22;
      2: return 8'h33;
      3: return 8'h44;
      4: return 8'h00;
      default: return 8'(8'h60 + i);
    endcase
  endfunction

  assign mem_rd = {mem[mi(mem_addr + 32'd3)], mem[mi(mem_addr + 32'd2)],
                   mem[mi(mem_addr + 32'd1)], mem[mi(mem_addr)]};

  always @(posedge clk) begin
    if (preload_req) begin
      for (int i = 0; i < 64; i++) mem[i] <= pre_byte(i);
      we_cnt <= 0;
    end else if (mem_we) begin
      for (int i = 0; i < 4; i++) mem[mi(mem_addr + AW'(i))] <= mem_wd[8*i +: 8];
      we_cnt <= we_cnt + 1;
    end
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  int   acc_q[$];
  int   neg_cnt = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  exp_t mon_e;
  int   mon_a;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: acceptance is sampled on the negedge before the accepting posedge.
  initial begin
    forever begin
      @(negedge clk);
      neg_cnt++;
      if (resp_valid === 1'b1) begin
        if (exp_q.size() == 0 || acc_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_resp: got resp_valid=1 expected no response");
        end else begin
          mon_e = exp_q.pop_front();
          mon_a = acc_q.pop_front();
          chk("resp_rdata", resp_rdata, mon_e.rdata);
          chk("resp_err", {31'b0, resp_err}, {31'b0, mon_e.err});
          chk("latency", 32'(neg_cnt - mon_a), 32'(mon_e.lat));
        end
      end else if (rst_n === 1'b1) begin
        chk("quiet_resp", {resp_rdata[30:0], resp_err}, 32'h0);
      end
      if (rst_n === 1'b1 && req_valid === 1'b1 && req_ready === 1'b1)
        acc_q.push_back(neg_cnt);
    end
  end

  task automatic send(input logic we, input logic [1:0] size, input logic sgn,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] erd, input logic eerr, input int elat,
                      input bit hold, input bit expect_resp);
    int n;
    exp_t e;
    if (expect_resp) begin
      e.rdata = erd;
      e.err   = eerr;
      e.lat   = elat;
      exp_q.push_back(e);
    end
    req_we     = we;
    req_size   = size;
    req_signed = sgn;
    req_addr   = addr;
    req_wdata  = wdata;
    req_valid  = 1'b1;
    n = 0;
    while (req_ready !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 20) begin
      n_chk++;
      n_fail++;
      $display("FAIL accept_timeout: got req_ready=0 for 20 cycles expected 1");
    end
    @(posedge clk); #1;
    if (!hold) begin
      req_valid  = 1'b0;
      req_we     = ~we;
      req_size   = 2'b11;
      req_signed = ~sgn;
      req_addr   = 32'hFFFF_FFF0;
      req_wdata  = 32'h0BAD_0BAD;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL resp_timeout: got %0d pending responses expected 0", exp_q.size());
      exp_q.delete();
      acc_q.delete();
    end
  endtask

  task automatic outputs_zero(input string tag);
    chk({tag, "_flags"}, {28'b0, req_ready, resp_valid, resp_err, mem_we}, 32'h0);
    chk({tag, "_mem_addr"}, mem_addr, 32'h0);
    chk({tag, "_mem_wd"}, mem_wd, 32'h0);
    chk({tag, "_resp_rdata"}, resp_rdata, 32'h0);
  endtask

  task automatic idle_check(input string tag);
    chk({tag, "_ready"}, {31'b0, req_ready}, 32'h1);
    chk({tag, "_mem_we"}, {31'b0, mem_we}, 32'h0);
    chk({tag, "_mem_addr"}, mem_addr, 32'h0);
    chk({tag, "_mem_wd"}, mem_wd, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  int w0;

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_signed = 1'b0; req_addr = '0; req_wdata = '0; preload_req = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    preload_req = 1'b0;
    outputs_zero("reset");
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("ready_after_reset", {31'b0, req_ready}, 32'h1);
    @(posedge clk); #1;
    idle_check("idle0");

    send(0, 2'b10, 0, 32'd0,  32'h0,        32'h4433_2211, 0, 2, 0, 1); drain();
    w0 = we_cnt;
    send(1, 2'b00, 0, 32'd1,  32'hCDEF_12AB, 32'h0,         0, 3, 0, 1); drain();
    chk("byte_store_writes", 32'(we_cnt - w0), 32'h1);
    send(0, 2'b10, 0, 32'd0,  32'h0,        32'h4433_AB11, 0, 2, 0, 1); drain();
    send(0, 2'b10, 0, 32'd4,  32'h0,        32'h6766_6500, 0, 2, 0, 1); drain();
    send(1, 2'b00, 0, 32'd5,  32'h5A5A_5A80, 32'h0,         0, 3, 0, 1); drain();
    send(0, 2'b00, 1, 32'd5,  32'h0,        32'hFFFF_FF80, 0, 2, 0, 1); drain();
    send(0, 2'b00, 0, 32'd5,  32'h0,        32'h0000_0080, 0, 2, 0, 1); drain();
    send(0, 2'b01, 1, 32'd4,  32'h0,        32'hFFFF_8000, 0, 2, 0, 1); drain();
    send(0, 2'b01, 0, 32'd4,  32'h0,        32'h0000_8000, 0, 2, 0, 1); drain();
    send(1, 2'b01, 0, 32'd12, 32'h1234_BEEF, 32'h0,         0, 3, 0, 1); drain();
    send(0, 2'b10, 0, 32'd12, 32'h0,        32'h6F6E_BEEF, 0, 2, 0, 1); drain();
    send(1, 2'b10, 0, 32'd16, 32'hA5A5_5A5A, 32'h0,         0, 2, 0, 1); drain();
    send(0, 2'b10, 0, 32'd16, 32'h0,        32'hA5A5_5A5A, 0, 2, 0, 1); drain();
    send(0, 2'b10, 0, 32'd32, 32'h0,        32'h8382_8180, 0, 2, 0, 1); drain();

    w0 = we_cnt;
    send(1, 2'b00, 0, 32'd33, 32'h0000_00EE, 32'h0, 1, 1, 0, 1); drain();
    send(0, 2'b11, 0, 32'd0,  32'h0,        32'h0, 1, 1, 0, 1); drain();
    send(0, 2'b10, 0, 32'hFFFF_FFFE, 32'h0, 32'h0, 1, 1, 0, 1); drain();
    chk("err_no_writes", 32'(we_cnt - w0), 32'h0);
    idle_check("idle1");

    w0 = we_cnt;
    send(1, 2'b10, 0, 32'd8, 32'hDEAD_BEEF, 32'h0, 0, 0, 0, 0);
    chk("in_wr_mem_we", {31'b0, mem_we}, 32'h1);
    #1;
    rst_n = 1'b0;
    #1;
    outputs_zero("rst_in_wr");
    rst_n = 1'b1;
    #1;
    chk("ready_after_pulse", {31'b0, req_ready}, 32'h1);
    @(posedge clk); #1;
    acc_q.delete();
    chk("mem8_unchanged", {mem[11], mem[10], mem[9], mem[8]}, 32'h6B6A_6968);
    chk("rst_no_write", 32'(we_cnt - w0), 32'h0);
    send(0, 2'b10, 0, 32'd8, 32'h0, 32'h6B6A_6968, 0, 2, 0, 1); drain();

    send(0, 2'b10, 0, 32'd0, 32'h0, 32'h4433_AB11, 0, 2, 1, 1);
    send(0, 2'b00, 1, 32'd1, 32'h0, 32'hFFFF_FFAB, 0, 2, 1, 1);
    send(0, 2'b01, 0, 32'd2, 32'h0, 32'h0000_4433, 0, 2, 0, 1);
    drain();
    repeat (3) @(posedge clk);
    #1;
    idle_check("idle_end");
    chk("acc_queue_empty", 32'(acc_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
